// File: rtl/pipe_ctrl.sv
// pipe_ctrl: redirect, bubble-window and stall control for the 3-stage core.
// Rev 1.0 - initial release.
`default_nettype none

module pipe_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int HOLD_MAX     = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_ex_i,
   input  logic        hold_bus_i,
   output logic        pc_jump_en_o,
   output logic [31:0] pc_jump_addr_o,
   output logic        hold_pc_o,
   output logic        hold_if_id_o,
   output logic        hold_id_ex_o,
   output logic        flush_if_id_o,
   output logic        flush_id_ex_o,
   output logic        busy_o,
   output logic        timeout_o
);

   localparam int              CW        = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0]   C_HMAX    = CW'(HOLD_MAX);
   localparam logic [CW-1:0]   C_HMAX_M1 = CW'(HOLD_MAX - 1);
   localparam logic [CW-1:0]   C_ONE     = CW'(1);
   localparam logic [3:0]      C_FINIT   = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          r_state;
   logic [3:0]      r_flush_cnt;
   logic            r_pend_valid;
   logic [31:0]     r_pend_addr;
   logic [CW-1:0]   r_hold_cnt;
   logic            r_timeout;

   logic            w_hold;
   logic            w_redirect;
   logic [31:0]     w_redir_addr;

   assign w_hold = hold_ex_i | hold_bus_i;

   always_comb begin
      w_redirect   = 1'b0;
      w_redir_addr = 32'h0;
      unique case (r_state)
         RUN: begin
            if (!w_hold && jump_en_i) begin
               w_redirect   = 1'b1;
               w_redir_addr = jump_addr_i;
            end
         end
         HOLD: begin
            // A jump captured during the stall takes priority over a fresh one.
            if (!w_hold && r_pend_valid) begin
               w_redirect   = 1'b1;
               w_redir_addr = r_pend_addr;
            end else if (!w_hold && jump_en_i) begin
               w_redirect   = 1'b1;
               w_redir_addr = jump_addr_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_flush_cnt  <= 4'd0;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= 32'h0;
      end else if (w_redirect) begin
         r_flush_cnt  <= C_FINIT;
         r_pend_valid <= 1'b0;
         r_state      <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_hold) begin
                  r_state <= HOLD;
                  if (jump_en_i) begin
                     r_pend_valid <= 1'b1;
                     r_pend_addr  <= jump_addr_i;
                  end
               end
            end
            HOLD: begin
               if (w_hold) begin
                  if (jump_en_i && !r_pend_valid) begin
                     r_pend_valid <= 1'b1;
                     r_pend_addr  <= jump_addr_i;
                  end
               end else begin
                  r_state <= RUN;
               end
            end
            FLUSH: begin
               // Leaving on the decrement to zero keeps the window at exactly FLUSH_CYCLES.
               if (r_flush_cnt == 4'd0) begin
                  r_state <= RUN;
               end else if (!w_hold) begin
                  r_flush_cnt <= r_flush_cnt - 4'd1;
                  if (r_flush_cnt == 4'd1) begin
                     r_state <= RUN;
                  end
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else if (w_hold) begin
         if (r_hold_cnt != C_HMAX) begin
            r_hold_cnt <= r_hold_cnt + C_ONE;
         end
         if (r_hold_cnt == C_HMAX_M1 || r_hold_cnt == C_HMAX) begin
            r_timeout <= 1'b1;
         end
      end else begin
         r_hold_cnt <= '0;
      end
   end

   assign pc_jump_en_o   = w_redirect;
   assign pc_jump_addr_o = w_redir_addr;
   assign hold_pc_o      = w_hold;
   assign hold_if_id_o   = w_hold;
   assign hold_id_ex_o   = w_hold;
   assign flush_if_id_o  = w_redirect | ((r_state == FLUSH) && (r_flush_cnt != 4'd0));
   assign flush_id_ex_o  = flush_if_id_o;
   assign busy_o         = (r_state != RUN) | r_pend_valid;
   assign timeout_o      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: two pipe_ctrl instances (different parameters) on shared stimulus,
// checked against a cycle-level reference model.
`default_nettype none

module tb_pipe_ctrl;

   localparam int F0 = 2, HM0 = 4;
   localparam int F1 = 3, HM1 = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] jump_addr = 32'h0;
   logic        hold_ex = 1'b0;
   logic        hold_bus = 1'b0;

   logic        pje  [2];
   logic [31:0] pja  [2];
   logic        hpc  [2];
   logic        hifid[2];
   logic        hidex[2];
   logic        fifid[2];
   logic        fidex[2];
   logic        busy [2];
   logic        tout [2];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: remaining bubble cycles, stall flag, deferred-jump queue, stall run length.
   int          flush_len[2] = '{F0, F1};
   int          hold_max [2] = '{HM0, HM1};
   int          bub      [2];
   bit          stalled  [2];
   logic [31:0] pend_q   [2][$];
   int          run_len  [2];
   bit          to_flag  [2];

   always #5 clk = ~clk;

   pipe_ctrl #(.FLUSH_CYCLES(F0), .HOLD_MAX(HM0)) dut0 (
      .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .hold_ex_i(hold_ex), .hold_bus_i(hold_bus),
      .pc_jump_en_o(pje[0]), .pc_jump_addr_o(pja[0]), .hold_pc_o(hpc[0]),
      .hold_if_id_o(hifid[0]), .hold_id_ex_o(hidex[0]), .flush_if_id_o(fifid[0]),
      .flush_id_ex_o(fidex[0]), .busy_o(busy[0]), .timeout_o(tout[0]));

   pipe_ctrl #(.FLUSH_CYCLES(F1), .HOLD_MAX(HM1)) dut1 (
      .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .hold_ex_i(hold_ex), .hold_bus_i(hold_bus),
      .pc_jump_en_o(pje[1]), .pc_jump_addr_o(pja[1]), .hold_pc_o(hpc[1]),
      .hold_if_id_o(hifid[1]), .hold_id_ex_o(hidex[1]), .flush_if_id_o(fifid[1]),
      .flush_id_ex_o(fidex[1]), .busy_o(busy[1]), .timeout_o(tout[1]));

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%h expected=%h t=%0t", tag, k, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         bub[k] = 0; stalled[k] = 1'b0; pend_q[k].delete(); run_len[k] = 0; to_flag[k] = 1'b0;
      end
   endtask

   task automatic check_all();
      bit          h, redir, fl;
      logic [31:0] tgt;
      h = hold_ex | hold_bus;
      for (int k = 0; k < 2; k++) begin
         redir = 1'b0; tgt = 32'h0;
         if (rst_n && bub[k] == 0) begin
            if (!h && stalled[k] && pend_q[k].size() > 0) begin
               redir = 1'b1; tgt = pend_q[k][0];
            end else if (!h && jump_en) begin
               redir = 1'b1; tgt = jump_addr;
            end
         end
         fl = redir || bub[k] > 0;
         chk("pc_jump_en",   k, 32'(pje[k]),   32'(redir));
         chk("pc_jump_addr", k, pja[k],        tgt);
         chk("flush_if_id",  k, 32'(fifid[k]), 32'(fl));
         chk("flush_id_ex",  k, 32'(fidex[k]), 32'(fl));
         chk("holds",        k, {29'd0, hpc[k], hifid[k], hidex[k]}, {29'd0, h, h, h});
         chk("busy",         k, 32'(busy[k]),  32'(stalled[k] || bub[k] > 0 || pend_q[k].size() > 0));
         chk("timeout",      k, 32'(tout[k]),  32'(to_flag[k]));
      end
   endtask

   task automatic model_advance();
      bit h;
      h = hold_ex | hold_bus;
      for (int k = 0; k < 2; k++) begin
         if (bub[k] == 0 && !h && (jump_en || (stalled[k] && pend_q[k].size() > 0))) begin
            bub[k] = flush_len[k] - 1;
            stalled[k] = 1'b0;
            pend_q[k].delete();
         end else if (bub[k] > 0) begin
            if (!h) bub[k]--;
         end else if (h) begin
            if (jump_en && pend_q[k].size() == 0) pend_q[k].push_back(jump_addr);
            stalled[k] = 1'b1;
         end else begin
            stalled[k] = 1'b0;
         end
         run_len[k] = h ? ((run_len[k] < hold_max[k]) ? run_len[k] + 1 : run_len[k]) : 0;
         if (run_len[k] == hold_max[k]) to_flag[k] = 1'b1;
      end
   endtask

   task automatic step(input bit je, input logic [31:0] ja, input bit hex, input bit hbus);
      @(negedge clk);
      jump_en = je; jump_addr = ja; hold_ex = hex; hold_bus = hbus;
      #2;
      check_all();
      @(posedge clk);
      model_advance();
   endtask

   task automatic do_reset();
      @(negedge clk);
      jump_en = 1'b0; jump_addr = 32'h0; hold_ex = 1'b0; hold_bus = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int burst;

   initial begin
      model_reset();
      #2;
      check_all();
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 32'h0, 0, 0);

      // Plain jump, then a wrong-path jump during the bubble window
      step(1, 32'h0000_0040, 0, 0);
      step(1, 32'h0000_0999, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0);

      // Jumps during a bus stall: the first is deferred, the second dropped
      step(0, 32'h0, 0, 1);
      step(1, 32'h0000_0100, 0, 1);
      step(1, 32'h0000_0200, 0, 1);
      step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0);

      // Jump coincident with a rising hold
      step(1, 32'h0000_0080, 1, 0);
      step(0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0);

      // Hold inside the flush window
      step(1, 32'h0000_0300, 0, 0);
      step(0, 32'h0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0);

      // Watchdog: 3 hold, 1 free, then a long stall, then reset clears it
      for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 32'h0, 0, 1);
      step(0, 32'h0, 0, 0);
      step(0, 32'h0, 0, 0);
      do_reset();
      step(0, 32'h0, 0, 0);

      // Reset in the middle of a bubble window and of a stall with a pending jump
      step(1, 32'h0000_0500, 0, 0);
      do_reset();
      step(0, 32'h0, 0, 0);
      step(1, 32'h0000_0600, 1, 0);
      do_reset();
      step(0, 32'h0, 0, 0);

      // Randomized traffic with bursty stalls
      burst = 0;
      for (int i = 0; i < 600; i++) begin
         if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 9);
         step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 7) == 0, burst > 0);
         if (burst > 0) burst--;
         if (i % 200 == 199) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
